switch_debounce: RTL and testbench

SWITCH_DEBOUNCE -- requirements
Module: switch_debounce

---
 rtl/debounce_pkg.sv | 30 +++
 rtl/switch_debounce_if.sv | 32 +++
 rtl/debounce_cell.sv | 172 +++++++++++++++++
 rtl/switch_debounce.sv | 76 +++++++
 tb/tb_switch_debounce.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/debounce_pkg.sv
// -----------------------------------------------------------------------------
// debounce_pkg
// Shared types and constants for the switch debouncer.
//   db_state_e         : per-channel debounce FSM state (2-bit encoding)
//   CNT_W / cnt_t      : width and type of the per-channel agreeing-sample count
//   DEFAULT_*          : default parameter values (50 MHz board, 10 switches)
//   tick_cnt_width()   : width of the shared tick-divider counter
// -----------------------------------------------------------------------------
package debounce_pkg;

  localparam int CNT_W                = 8;
  localparam int DEFAULT_WIDTH        = 10;
  localparam int DEFAULT_TICK_DIV     = 50000;
  localparam int DEFAULT_STABLE_TICKS = 10;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    CHK_HI    = 2'd1,
    STABLE_HI = 2'd2,
    CHK_LO    = 2'd3
  } db_state_e;

  // A divider of 2 still needs one bit to hold the value 1.
  function automatic int tick_cnt_width(input int div);
    return (div > 2) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/switch_debounce_if.sv
// -----------------------------------------------------------------------------
// switch_debounce_if
// Bundles the switch-side signals of the debouncer.
//   sw_raw   : raw, asynchronous, bouncing switch levels
//   sw_clean : debounced levels
//   sw_rise  : one-cycle pulse on accepted 0->1 (only with DEBOUNCE_EDGE_EN)
//   sw_fall  : one-cycle pulse on accepted 1->0 (only with DEBOUNCE_EDGE_EN)
// Modports: master = switch/consumer side, slave = debouncer.
// Configuration macro: DEBOUNCE_EDGE_EN.
// -----------------------------------------------------------------------------
interface switch_debounce_if
  import debounce_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic [WIDTH-1:0] sw_raw;
  logic [WIDTH-1:0] sw_clean;
`ifdef DEBOUNCE_EDGE_EN
  logic [WIDTH-1:0] sw_rise;
  logic [WIDTH-1:0] sw_fall;
`endif

`ifdef DEBOUNCE_EDGE_EN
  modport master (output sw_raw, input  sw_clean, input  sw_rise, input  sw_fall);
  modport slave  (input  sw_raw, output sw_clean, output sw_rise, output sw_fall);
`else
  modport master (output sw_raw, input  sw_clean);
  modport slave  (input  sw_raw, output sw_clean);
`endif

endinterface

// File: rtl/debounce_cell.sv
// -----------------------------------------------------------------------------
// debounce_cell
// One debounced channel: 2-flop synchronizer, 4-state accept FSM with an
// agreeing-sample counter, and the registered clean level (plus edge pulses
// when DEBOUNCE_EDGE_EN is defined).
// Ports:
//   i_clk    : clock, rising edge
//   i_rst    : asynchronous active-high reset
//   i_tick   : one-cycle sample strobe from the shared divider
//   i_raw    : raw switch level (asynchronous)
//   o_clean  : debounced level, registered
//   o_rise   : registered pulse, coincident with o_clean 0->1 (macro only)
//   o_fall   : registered pulse, coincident with o_clean 1->0 (macro only)
// Configuration macro: DEBOUNCE_EDGE_EN.
// -----------------------------------------------------------------------------
module debounce_cell
  import debounce_pkg::*;
#(
  parameter int STABLE_TICKS = DEFAULT_STABLE_TICKS
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_tick,
  input  logic i_raw,
  output logic o_clean
`ifdef DEBOUNCE_EDGE_EN
  ,
  output logic o_rise,
  output logic o_fall
`endif
);

  localparam cnt_t STABLE_CNT   = cnt_t'(STABLE_TICKS);
  localparam bit   SINGLE_TICK  = (STABLE_TICKS == 1);

  logic      r_sync1;
  logic      r_sync2;
  db_state_e r_state;
  cnt_t      r_cnt;
  logic      r_clean;

  db_state_e w_state_nxt;
  cnt_t      w_cnt_nxt;
  logic      w_clean_nxt;
  cnt_t      w_cnt_inc;
  logic      w_cnt_done;

  assign w_cnt_inc  = r_cnt + cnt_t'(1);
  assign w_cnt_done = (w_cnt_inc == STABLE_CNT);

  // State register, synchronizer and clean level.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_state <= STABLE_LO;
      r_cnt   <= '0;
      r_clean <= 1'b0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_clean <= w_clean_nxt;
    end
  end

  // Next-state logic. Only tick cycles move the FSM; the decision uses the
  // synchronized sample alone, so a bounce on the completing tick is judged
  // purely by what r_sync2 holds at that edge.
  always_comb begin
    // NOTE: every output gets its hold value first so no path infers a latch.
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_clean_nxt = r_clean;

    if (i_tick) begin
      unique case (r_state)
        STABLE_LO: begin
          if (r_sync2) begin
            if (SINGLE_TICK) begin
              w_state_nxt = STABLE_HI;
              w_cnt_nxt   = '0;
              w_clean_nxt = 1'b1;
            end else begin
              w_state_nxt = CHK_HI;
              w_cnt_nxt   = cnt_t'(1);
            end
          end else begin
            w_cnt_nxt = '0;
          end
        end

        CHK_HI: begin
          if (r_sync2) begin
            if (w_cnt_done) begin
              w_state_nxt = STABLE_HI;
              w_cnt_nxt   = '0;
              w_clean_nxt = 1'b1;
            end else begin
              w_cnt_nxt = w_cnt_inc;
            end
          end else begin
            w_state_nxt = STABLE_LO;
            w_cnt_nxt   = '0;
          end
        end

        STABLE_HI: begin
          if (!r_sync2) begin
            if (SINGLE_TICK) begin
              w_state_nxt = STABLE_LO;
              w_cnt_nxt   = '0;
              w_clean_nxt = 1'b0;
            end else begin
              w_state_nxt = CHK_LO;
              w_cnt_nxt   = cnt_t'(1);
            end
          end else begin
            w_cnt_nxt = '0;
          end
        end

        CHK_LO: begin
          if (!r_sync2) begin
            if (w_cnt_done) begin
              w_state_nxt = STABLE_LO;
              w_cnt_nxt   = '0;
              w_clean_nxt = 1'b0;
            end else begin
              w_cnt_nxt = w_cnt_inc;
            end
          end else begin
            w_state_nxt = STABLE_HI;
            w_cnt_nxt   = '0;
          end
        end

        default: begin
          w_state_nxt = STABLE_LO;
          w_cnt_nxt   = '0;
          w_clean_nxt = 1'b0;
        end
      endcase
    end
  end

  assign o_clean = r_clean;

`ifdef DEBOUNCE_EDGE_EN
  logic r_rise;
  logic r_fall;

  // Pulses are derived from the next clean value so they land on the same
  // edge that updates r_clean.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_rise <= w_clean_nxt & ~r_clean;
      r_fall <= ~w_clean_nxt & r_clean;
    end
  end

  assign o_rise = r_rise;
  assign o_fall = r_fall;
`endif

endmodule

// File: rtl/switch_debounce.sv
// -----------------------------------------------------------------------------
// switch_debounce
// WIDTH independent switch debouncers sharing one sample-tick divider.
// Ports:
//   CLOCK_50 : clock, all state updates on the rising edge
//   reset    : asynchronous active-high reset
//   sw_bus   : switch_debounce_if.slave (sw_raw in; sw_clean, and with
//              DEBOUNCE_EDGE_EN also sw_rise/sw_fall, out)
// Parameters:
//   WIDTH        : channel count (must match the interface WIDTH)
//   TICK_DIV     : clock cycles per sample tick, 2..2^20
//   STABLE_TICKS : agreeing samples needed to accept a new level, 1..255
// Configuration macro: DEBOUNCE_EDGE_EN (adds sw_rise/sw_fall pulses).
// -----------------------------------------------------------------------------
module switch_debounce
  import debounce_pkg::*;
#(
  parameter int WIDTH        = DEFAULT_WIDTH,
  parameter int TICK_DIV     = DEFAULT_TICK_DIV,
  parameter int STABLE_TICKS = DEFAULT_STABLE_TICKS
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  switch_debounce_if.slave sw_bus
);

  localparam int TW = tick_cnt_width(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  logic [TW-1:0]    r_tick_cnt;
  logic             w_tick;
  logic [WIDTH-1:0] w_clean;

  // Free-running divider; the tick is the single cycle at the top of the
  // count, so the first tick after reset arrives TICK_DIV edges later.
  assign w_tick = (r_tick_cnt == TICK_LAST);

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + TW'(1);
    end
  end

`ifdef DEBOUNCE_EDGE_EN
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
`endif

  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    debounce_cell #(
      .STABLE_TICKS (STABLE_TICKS)
    ) u_cell (
      .i_clk   (CLOCK_50),
      .i_rst   (reset),
      .i_tick  (w_tick),
      .i_raw   (sw_bus.sw_raw[g]),
      .o_clean (w_clean[g])
`ifdef DEBOUNCE_EDGE_EN
      ,
      .o_rise  (w_rise[g]),
      .o_fall  (w_fall[g])
`endif
    );
  end

  assign sw_bus.sw_clean = w_clean;
`ifdef DEBOUNCE_EDGE_EN
  assign sw_bus.sw_rise  = w_rise;
  assign sw_bus.sw_fall  = w_fall;
`endif

endmodule

// File: tb/tb_switch_debounce.sv
// -----------------------------------------------------------------------------
// tb_switch_debounce
// Scoreboard bench for switch_debounce (WIDTH=10, TICK_DIV=4, STABLE_TICKS=3).
// Each accepted level change is predicted when the stimulus is driven (cycle,
// clean vector, edge pulses) and popped when the DUT outputs change.
// Edge numbering: cyc=k after the k-th rising edge following reset release;
// the FSMs sample on edges with k % TICK_DIV == 0.
// -----------------------------------------------------------------------------
module tb_switch_debounce;

  localparam int WIDTH = 10;
  localparam int TD    = 4;
  localparam int ST    = 3;

  typedef logic [WIDTH-1:0] vec_t;

  typedef struct {
    int   cyc;
    vec_t clean;
    vec_t rise;
    vec_t fall;
  } ev_t;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  switch_debounce_if #(.WIDTH(WIDTH)) sw_if ();

  switch_debounce #(
    .WIDTH        (WIDTH),
    .TICK_DIV     (TD),
    .STABLE_TICKS (ST)
  ) dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .sw_bus   (sw_if.slave)
  );

  ev_t  sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   last_event_cyc = -1;
  vec_t exp_clean = '0;
  vec_t prev_clean = '0;

  always @(posedge clk or posedge reset) begin
    if (reset) cyc = 0;
    else       cyc = cyc + 1;
  end

  // First sampling edge at or after edge e.
  function automatic int next_tick(input int e);
    int k;
    k = e;
    while ((k % TD) != 0 || k == 0) k++;
    return k;
  endfunction

  // Drive a new steady raw vector (call right after a negedge) and predict
  // the acceptance of every bit that differs from the expected clean level.
  task automatic push_step(input vec_t new_raw);
    vec_t changed;
    ev_t  e;
    int   j;
    changed = new_raw ^ exp_clean;
    j = cyc + 1;
    sw_if.sw_raw = new_raw;
    if (changed != '0) begin
      e.cyc   = next_tick(j + 2) + (ST - 1) * TD;
      e.clean = new_raw;
`ifdef DEBOUNCE_EDGE_EN
      e.rise  = changed & new_raw;
      e.fall  = changed & ~new_raw;
`else
      e.rise  = '0;
      e.fall  = '0;
`endif
      sb.push_back(e);
      exp_clean = new_raw;
    end
  endtask

  task automatic wait_drain(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL %s: %0d expected events still pending after %0d cycles, required 0",
               name, sb.size(), budget);
      sb.delete();
    end
  endtask

  task automatic check_clean(input string name);
    total++;
    if (sw_if.sw_clean !== exp_clean) begin
      bad++;
      $display("FAIL %s: sw_clean=%h required=%h", name, sw_if.sw_clean, exp_clean);
    end
  endtask

  // Monitor: every observed change of the outputs must match the head of the
  // scoreboard; outside reset nothing may change unannounced.
  always @(negedge clk) begin : mon
    vec_t r;
    vec_t f;
    ev_t  e;
`ifdef DEBOUNCE_EDGE_EN
    r = sw_if.sw_rise;
    f = sw_if.sw_fall;
`else
    r = '0;
    f = '0;
`endif
    if (reset) begin
      prev_clean = sw_if.sw_clean;
    end else if (sw_if.sw_clean !== prev_clean || r != '0 || f != '0) begin
      total++;
      last_event_cyc = cyc;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_event: cyc=%0d clean=%h rise=%h fall=%h, required no change",
                 cyc, sw_if.sw_clean, r, f);
      end else begin
        e = sb.pop_front();
        if (e.cyc !== cyc || e.clean !== sw_if.sw_clean || e.rise !== r || e.fall !== f) begin
          bad++;
          $display("FAIL event: cyc=%0d clean=%h rise=%h fall=%h, required cyc=%0d clean=%h rise=%h fall=%h",
                   cyc, sw_if.sw_clean, r, f, e.cyc, e.clean, e.rise, e.fall);
        end
      end
      prev_clean = sw_if.sw_clean;
    end
  end

  task automatic test_reset();
    reset = 1'b0;
    sw_if.sw_raw = 10'h3FF;
    #2 reset = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (sw_if.sw_clean !== '0) begin
      bad++;
      $display("FAIL reset_clean: sw_clean=%h required=000", sw_if.sw_clean);
    end
`ifdef DEBOUNCE_EDGE_EN
    total++;
    if (sw_if.sw_rise !== '0 || sw_if.sw_fall !== '0) begin
      bad++;
      $display("FAIL reset_edges: rise=%h fall=%h required 000/000", sw_if.sw_rise, sw_if.sw_fall);
    end
`endif
    reset = 1'b0;
    exp_clean = '0;
    push_step(10'h3FF);
    wait_drain("reset_release", 40);
    check_clean("reset_release_final");
  endtask

  task automatic test_fall_all();
    @(negedge clk);
    push_step('0);
    wait_drain("fall_all", 40);
    check_clean("fall_all_final");
  endtask

  task automatic test_single_rise();
    int j0;
    @(negedge clk);
    j0 = cyc;
    push_step(10'h200);
    wait_drain("single_rise", 40);
    total++;
    if (last_event_cyc - j0 > 2 + ST * TD) begin
      bad++;
      $display("FAIL single_rise_latency: %0d cycles, required <= %0d",
               last_event_cyc - j0, 2 + ST * TD);
    end
    check_clean("single_rise_final");
  endtask

  task automatic test_bounce();
    vec_t raw;
    raw = sw_if.sw_raw;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      raw[0] = ~raw[0];
      sw_if.sw_raw = raw;
      repeat (4) @(negedge clk);
    end
    repeat (20) @(negedge clk);
    check_clean("bounce_final");
    total++;
    if (sw_if.sw_clean[0] !== 1'b0) begin
      bad++;
      $display("FAIL bounce_bit0: sw_clean[0]=%b required=0", sw_if.sw_clean[0]);
    end
  endtask

  task automatic test_glitch();
    vec_t raw;
    raw = sw_if.sw_raw;
    @(negedge clk);
    raw[0] = 1'b1;
    sw_if.sw_raw = raw;
    repeat (8) @(negedge clk);
    raw[0] = 1'b0;
    sw_if.sw_raw = raw;
    repeat (4) @(negedge clk);
    raw[0] = 1'b1;
    push_step(raw);
    wait_drain("glitch", 40);
    check_clean("glitch_final");
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    push_step(sw_if.sw_raw | 10'h088);
    wait_drain("pair_rise", 40);
    check_clean("pair_rise_final");
    @(negedge clk);
    push_step(sw_if.sw_raw & ~10'h088);
    wait_drain("pair_fall", 40);
    check_clean("pair_fall_final");
  endtask

  task automatic test_reset_mid();
    vec_t raw;
    int   t2;
    int   n;
    raw = sw_if.sw_raw;
    @(negedge clk);
    raw[2] = 1'b1;
    sw_if.sw_raw = raw;
    t2 = next_tick(cyc + 3) + TD;
    n = 0;
    while (cyc != t2 && n < 50) begin
      @(negedge clk);
      n++;
    end
    reset = 1'b1;
    #1;
    total++;
    if (sw_if.sw_clean !== '0) begin
      bad++;
      $display("FAIL reset_mid_clean: sw_clean=%h required=000 (cyc=%0d)", sw_if.sw_clean, cyc);
    end
    exp_clean = '0;
    sb.delete();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    push_step(raw);
    wait_drain("reset_mid_reaccept", 40);
    check_clean("reset_mid_final");
  endtask

  initial begin
    test_reset();
    test_fall_all();
    test_single_rise();
    test_bounce();
    test_glitch();
    test_back_to_back();
    test_reset_mid();
    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
